minmax_tracker: RTL and testbench
=================================

Name: minmax_tracker

Overview:
Streaming stage downstream of the 4-bit signed/unsigned magnitude comparator. It accepts a sequence of W-bit samples over a valid/ready handshake and keeps a running maximum and minimum, plus a sample count. It also exports the one-hot {gt,eq,lt} result of each new sample against the previous maximum. Comparison mode (two's-complement signed or unsigned) is latched per run, and the tracker saturates when the count is full.

Parameters:
W, 4, sample width in bits
CNT_W, 4, sample counter width; full at 2^CNT_W-1 samples

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous run restart
mode  input  1  1 = two's-complement signed compare, 0 = unsigned; latched on the first sample of a run
in_valid  input  1  sample present
in_data  input  W  sample value
in_ready  output  1  tracker can accept a sample
max_val  output  W  running maximum
min_val  output  W  running minimum
count  output  CNT_W  samples accepted this run
have_data  output  1  at least one sample accepted
last_cmp  output  3  one-hot {gt,eq,lt}: newest sample vs previous max_val
mode_q  output  1  mode latched for the current run

Behaviour:
- Reset (rst_n low, async) and its effect:
  - state EMPTY
  - max_val, min_val, count = 0
  - last_cmp = 3'b000
  - have_data = 0, mode_q = 0
  - in_ready = 1
- Accept condition: in_valid && in_ready at a rising edge. All outputs are registered, so an accepted sample is visible one cycle later.
- States:
  - EMPTY, on accept: max_val = min_val = in_data; count = 1; last_cmp = 010; mode_q = mode; have_data = 1; go to TRACK.
  - TRACK, on accept: compare in_data against the pre-update max_val and min_val, using the mode_q interpretation.
    - in_data > max_val: max_val <= in_data.
    - in_data < min_val: min_val <= in_data.
    - last_cmp = result against max_val (100 gt, 010 eq, 001 lt).
    - count++. If the new count equals 2^CNT_W-1, go to FULL.
  - FULL: in_ready = 0. Samples are not accepted and every output holds.
- in_ready = 1 in EMPTY and TRACK, 0 in FULL (decoded combinationally from state).
- Mode:
  - mode changes after the first sample are ignored until clear or reset.
  - Signed compare treats bit W-1 as the sign: negative < non-negative; same signs compare by magnitude.
- Arithmetic: comparison is done without subtraction overflow hazards (sign-aware compare, not the sign bit of A-B). No width growth on max/min.
- clear:
  - Synchronous, highest priority, and applies in any state.
  - It produces the reset values and EMPTY next cycle.
  - A sample presented in the same cycle as clear is dropped and not counted.
- No sample accepted: outputs hold, and last_cmp holds its previous value.
- Asserting rst_n low mid-run discards the run immediately (asynchronous). The first edge after release is EMPTY with in_ready = 1.

Decomposition:
- Shared package minmax_pkg holds:
  - state enum {EMPTY, TRACK, FULL}
  - one-hot constants CMP_GT = 3'b100, CMP_EQ = 3'b010, CMP_LT = 3'b001
- One combinational sub-module, mag_cmp: inputs a, b, signed_mode; output one-hot {gt,eq,lt}. Two instances: sample vs max, sample vs min.

Test Plan:
- Signed run:
  - Stimulus: reset, mode = 1, samples 4'hF, 4'h1, 4'h7.
  - After each: last_cmp 010, 100, 100.
  - Final: max_val = 7, min_val = F (-1), count = 3.
- Unsigned run:
  - Stimulus: mode = 0, same samples.
  - After each: last_cmp 010, 001, 001.
  - Final: max_val = F, min_val = 1, count = 3.
- Equal and mode toggle:
  - Stimulus: mode = 0, samples 5, 5; then toggle mode = 1 and send 4'h9.
  - Required: last_cmp 010 then 100; max_val = 9, min_val = 5, mode_q stays 0.
- Saturation:
  - Stimulus: 15 back-to-back samples, then a 16th sample 4'hE held valid.
  - Required: count = 15; in_ready = 0 from the cycle after the 15th; the 16th is ignored and all outputs hold.
- Clear with valid:
  - Stimulus: after 3 samples, assert clear together with in_valid and in_data = 4'h3.
  - Required: next cycle count = 0, have_data = 0, state EMPTY, sample dropped. The next sample 4'h3 yields max = min = 3.
- Async reset mid-run:
  - Stimulus: drop rst_n between edges during TRACK.
  - Required: outputs go to reset values immediately, without waiting for a clock edge; in_ready = 1 after release.

Source files
------------

// File: rtl/minmax_tracker_pkg.sv
// ============================================================================
//  Module   : minmax_pkg
//  Purpose  : Shared types and constants for the min/max tracker slice:
//             tracker state encoding and one-hot compare result codes.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package minmax_pkg;

  // Tracker run state
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    TRACK = 2'd1,
    FULL  = 2'd2
  } state_t;

  // One-hot compare result codes, ordered {gt, eq, lt}
  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_EQ = 3'b010;
  localparam logic [2:0] CMP_LT = 3'b001;

endpackage : minmax_pkg

`default_nettype wire

// File: rtl/minmax_tracker_if.sv
// ============================================================================
//  Module   : minmax_tracker_if
//  Purpose  : Valid/ready sample stream feeding the min/max tracker.
//             master = sample source, slave = tracker.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface minmax_tracker_if #(
  parameter int W = 4
) ();

  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );

endinterface : minmax_tracker_if

`default_nettype wire

// File: rtl/minmax_tracker_mag_cmp.sv
// ============================================================================
//  Module   : mag_cmp
//  Purpose  : Combinational magnitude compare of a against b, returning a
//             one-hot {gt,eq,lt}. In signed mode the MSB is the sign; the
//             compare is sign-aware rather than relying on the sign of a-b,
//             so there is no overflow hazard.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mag_cmp
  import minmax_pkg::*;
#(
  parameter int W = 4
) (
  input  wire logic [W-1:0] a,
  input  wire logic [W-1:0] b,
  input  wire logic         signed_mode,
  output logic      [2:0]   cmp
);

  // Opposite signs decide the signed result directly; otherwise plain magnitude
  always_comb begin
    cmp = CMP_EQ;
    if (signed_mode && (a[W-1] != b[W-1])) begin
      cmp = a[W-1] ? CMP_LT : CMP_GT;
    end else if (a > b) begin
      cmp = CMP_GT;
    end else if (a < b) begin
      cmp = CMP_LT;
    end
  end

endmodule : mag_cmp

`default_nettype wire

// File: rtl/minmax_tracker.sv
// ============================================================================
//  Module   : minmax_tracker
//  Purpose  : Streaming running max/min tracker with sample count, per-run
//             latched signed/unsigned mode, newest-vs-max compare result and
//             saturation once the counter is full.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module minmax_tracker
  import minmax_pkg::*;
#(
  parameter int W     = 4,
  parameter int CNT_W = 4
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             clear,
  input  wire logic             mode,
  minmax_tracker_if.slave       s_in,
  output logic      [W-1:0]     max_val,
  output logic      [W-1:0]     min_val,
  output logic      [CNT_W-1:0] count,
  output logic                  have_data,
  output logic      [2:0]       last_cmp,
  output logic                  mode_q
);

  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

  state_t           r_state,     w_state_nxt;
  logic [W-1:0]     r_max,       w_max_nxt;
  logic [W-1:0]     r_min,       w_min_nxt;
  logic [CNT_W-1:0] r_count,     w_count_nxt;
  logic             r_have_data, w_have_data_nxt;
  logic [2:0]       r_last_cmp,  w_last_cmp_nxt;
  logic             r_mode_q,    w_mode_q_nxt;

  logic             w_ready;
  logic             w_accept;
  logic [2:0]       w_cmp_max;
  logic [2:0]       w_cmp_min;

  assign w_ready       = (r_state != FULL);
  assign w_accept      = s_in.in_valid && w_ready;
  assign s_in.in_ready = w_ready;

  // New sample against the current extremes, interpreted with the run's mode
  mag_cmp #(.W(W)) u_cmp_max (
    .a           (s_in.in_data),
    .b           (r_max),
    .signed_mode (r_mode_q),
    .cmp         (w_cmp_max)
  );

  mag_cmp #(.W(W)) u_cmp_min (
    .a           (s_in.in_data),
    .b           (r_min),
    .signed_mode (r_mode_q),
    .cmp         (w_cmp_min)
  );

  // Next-state and next-output decode; clear overrides any accept
  always_comb begin
    w_state_nxt     = r_state;
    w_max_nxt       = r_max;
    w_min_nxt       = r_min;
    w_count_nxt     = r_count;
    w_have_data_nxt = r_have_data;
    w_last_cmp_nxt  = r_last_cmp;
    w_mode_q_nxt    = r_mode_q;

    if (clear) begin
      w_state_nxt     = EMPTY;
      w_max_nxt       = '0;
      w_min_nxt       = '0;
      w_count_nxt     = '0;
      w_have_data_nxt = 1'b0;
      w_last_cmp_nxt  = 3'b000;
      w_mode_q_nxt    = 1'b0;
    end else if (w_accept) begin
      case (r_state)
        EMPTY: begin
          w_max_nxt       = s_in.in_data;
          w_min_nxt       = s_in.in_data;
          w_count_nxt     = c_cnt_one;
          w_have_data_nxt = 1'b1;
          w_last_cmp_nxt  = CMP_EQ;
          w_mode_q_nxt    = mode;
          w_state_nxt     = (c_cnt_one == c_cnt_max) ? FULL : TRACK;
        end
        TRACK: begin
          if (w_cmp_max == CMP_GT) w_max_nxt = s_in.in_data;
          if (w_cmp_min == CMP_LT) w_min_nxt = s_in.in_data;
          w_last_cmp_nxt = w_cmp_max;
          w_count_nxt    = r_count + c_cnt_one;
          if ((r_count + c_cnt_one) == c_cnt_max) w_state_nxt = FULL;
        end
        default: begin
          // FULL never accepts; everything holds
        end
      endcase
    end
  end

  // State and output registers, discarded immediately by async reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= EMPTY;
      r_max       <= '0;
      r_min       <= '0;
      r_count     <= '0;
      r_have_data <= 1'b0;
      r_last_cmp  <= 3'b000;
      r_mode_q    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_max       <= w_max_nxt;
      r_min       <= w_min_nxt;
      r_count     <= w_count_nxt;
      r_have_data <= w_have_data_nxt;
      r_last_cmp  <= w_last_cmp_nxt;
      r_mode_q    <= w_mode_q_nxt;
    end
  end

  assign max_val   = r_max;
  assign min_val   = r_min;
  assign count     = r_count;
  assign have_data = r_have_data;
  assign last_cmp  = r_last_cmp;
  assign mode_q    = r_mode_q;

endmodule : minmax_tracker

`default_nettype wire

// File: tb/tb_minmax_tracker.sv
// ============================================================================
//  Module   : tb_minmax_tracker
//  Purpose  : Directed self-checking bench for minmax_tracker.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_minmax_tracker;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       mode;
  logic [3:0] max_val;
  logic [3:0] min_val;
  logic [3:0] count;
  logic       have_data;
  logic [2:0] last_cmp;
  logic       mode_q;

  int n_checks;
  int n_errors;

  minmax_tracker_if #(.W(4)) u_if ();

  minmax_tracker #(.W(4), .CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (clear),
    .mode      (mode),
    .s_in      (u_if.slave),
    .max_val   (max_val),
    .min_val   (min_val),
    .count     (count),
    .have_data (have_data),
    .last_cmp  (last_cmp),
    .mode_q    (mode_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // One accepted-sample cycle; returns 1 ns after the edge
  task automatic send(input logic [3:0] d);
    u_if.in_valid = 1'b1;
    u_if.in_data  = d;
    @(posedge clk);
    #1;
    u_if.in_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_max"},   32'(max_val),          32'h0);
    check_eq({tag, "_min"},   32'(min_val),          32'h0);
    check_eq({tag, "_cnt"},   32'(count),            32'h0);
    check_eq({tag, "_cmp"},   32'(last_cmp),         32'h0);
    check_eq({tag, "_have"},  32'(have_data),        32'h0);
    check_eq({tag, "_modeq"}, 32'(mode_q),           32'h0);
    check_eq({tag, "_rdy"},   32'(u_if.in_ready),    32'h1);
  endtask

  initial begin
    n_checks      = 0;
    n_errors      = 0;
    rst_n         = 1'b0;
    clear         = 1'b0;
    mode          = 1'b0;
    u_if.in_valid = 1'b0;
    u_if.in_data  = 4'h0;

    // Reset state
    #12;
    check_reset_vals("rst");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Signed run: F(-1), 1, 7
    mode = 1'b1;
    send(4'hF); check_eq("s_cmp0", 32'(last_cmp), 32'b010);
    send(4'h1); check_eq("s_cmp1", 32'(last_cmp), 32'b100);
    send(4'h7); check_eq("s_cmp2", 32'(last_cmp), 32'b100);
    check_eq("s_max",   32'(max_val), 32'h7);
    check_eq("s_min",   32'(min_val), 32'hF);
    check_eq("s_cnt",   32'(count),   32'd3);
    check_eq("s_modeq", 32'(mode_q),  32'h1);

    // Unsigned run with the same samples
    do_clear();
    mode = 1'b0;
    send(4'hF); check_eq("u_cmp0", 32'(last_cmp), 32'b010);
    send(4'h1); check_eq("u_cmp1", 32'(last_cmp), 32'b001);
    send(4'h7); check_eq("u_cmp2", 32'(last_cmp), 32'b001);
    check_eq("u_max", 32'(max_val), 32'hF);
    check_eq("u_min", 32'(min_val), 32'h1);
    check_eq("u_cnt", 32'(count),   32'd3);

    // Equal samples, then a mode toggle that must be ignored
    do_clear();
    mode = 1'b0;
    send(4'h5); check_eq("e_cmp0", 32'(last_cmp), 32'b010);
    send(4'h5); check_eq("e_cmp1", 32'(last_cmp), 32'b010);
    mode = 1'b1;
    send(4'h9); check_eq("e_cmp2", 32'(last_cmp), 32'b100);
    check_eq("e_max",   32'(max_val), 32'h9);
    check_eq("e_min",   32'(min_val), 32'h5);
    check_eq("e_modeq", 32'(mode_q),  32'h0);
    check_eq("e_cnt",   32'(count),   32'd3);

    // Saturation: samples 1..15 back to back, then 4'hE held valid
    do_clear();
    mode = 1'b0;
    u_if.in_valid = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      u_if.in_data = 4'(i);
      @(posedge clk);
      #1;
      if (i == 14) begin
        check_eq("f_cnt14", 32'(count),         32'd14);
        check_eq("f_rdy14", 32'(u_if.in_ready), 32'h1);
      end
    end
    check_eq("f_rdy15", 32'(u_if.in_ready), 32'h0);
    u_if.in_data = 4'hE;
    repeat (3) @(posedge clk);
    #1;
    u_if.in_valid = 1'b0;
    check_eq("f_cnt", 32'(count),         32'd15);
    check_eq("f_max", 32'(max_val),       32'hF);
    check_eq("f_min", 32'(min_val),       32'h1);
    check_eq("f_cmp", 32'(last_cmp),      32'b100);
    check_eq("f_rdy", 32'(u_if.in_ready), 32'h0);

    // Clear in the same cycle as a valid sample
    do_clear();
    send(4'h8);
    send(4'h2);
    send(4'hA);
    check_eq("c_pre_cnt", 32'(count), 32'd3);
    clear         = 1'b1;
    u_if.in_valid = 1'b1;
    u_if.in_data  = 4'h3;
    @(posedge clk);
    #1;
    clear         = 1'b0;
    u_if.in_valid = 1'b0;
    check_reset_vals("clr");
    send(4'h3);
    check_eq("c_max", 32'(max_val),  32'h3);
    check_eq("c_min", 32'(min_val),  32'h3);
    check_eq("c_cnt", 32'(count),    32'd1);
    check_eq("c_cmp", 32'(last_cmp), 32'b010);

    // Async reset between edges during TRACK
    send(4'h6);
    mode = 1'b1;
    do_clear();
    send(4'hC);
    send(4'h4);
    check_eq("a_pre_cnt",   32'(count),  32'd2);
    check_eq("a_pre_modeq", 32'(mode_q), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("arst");
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("a_rdy", 32'(u_if.in_ready), 32'h1);
    check_eq("a_cnt", 32'(count),         32'd0);
    mode = 1'b0;
    send(4'h6);
    check_eq("a_cnt1", 32'(count),   32'd1);
    check_eq("a_max1", 32'(max_val), 32'h6);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule : tb_minmax_tracker

`default_nettype wire
